// File: rtl/ysyx_23060278_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// AXI read response codes and the architectural reset pc.
package ysyx_23060278_ifu_pkg;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_IDLE = 3'd1,
    S_AR   = 3'd2,
    S_R    = 3'd3,
    S_OUT  = 3'd4
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060278_ifu_outbuf.sv
// Holding register for a fetched instruction; keeps inst/inst_pc/inst_fault
// stable from load until the decode stage accepts them.
module ysyx_23060278_ifu_outbuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              load_fault,
  input  logic              out_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  output logic              inst_valid
);

  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              valid_q, valid_d;

  // Loads only ever arrive while empty, so held data cannot be overwritten.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    valid_d = valid_q;
    if (load) begin
      inst_d  = load_inst;
      pc_d    = load_pc;
      fault_d = load_fault;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      valid_q <= valid_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = pc_q;
  assign inst_fault = fault_q;
  assign inst_valid = valid_q;

endmodule

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: latches pc, performs one AR/R read and presents the
// instruction to decode over valid/ready. One fetch in flight at most.
module ysyx_23060278_ifu
  import ysyx_23060278_ifu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit BOOT_FETCH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_go,
  output logic              busy,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  output logic              inst_valid,
  input  logic              inst_ready
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              busy_q, busy_d;
  logic              load;
  logic [DATA_W-1:0] load_inst;
  logic [ADDR_W-1:0] load_pc;
  logic              load_fault;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    load       = 1'b0;
    load_inst  = '0;
    load_pc    = addr_q;
    load_fault = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (BOOT_FETCH) begin
          state_d = S_AR;
          addr_d  = pc;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (fetch_go) begin
          addr_d = pc;
          // Misaligned pc faults immediately without touching the bus.
          if (pc[1:0] != 2'b00) begin
            state_d    = S_OUT;
            load       = 1'b1;
            load_pc    = pc;
            load_fault = 1'b1;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          state_d    = S_OUT;
          load       = 1'b1;
          load_inst  = rdata;
          load_fault = (rresp != RESP_OKAY);
        end
      end
      S_OUT: begin
        if (inst_valid && inst_ready) state_d = S_IDLE;
      end
      default: state_d = S_BOOT;
    endcase
    // Channel strobes decode the next state so they are registered outputs.
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_BOOT;
      addr_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
    end
  end

  assign araddr  = addr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign busy    = busy_q;

  ysyx_23060278_ifu_outbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_inst  (load_inst),
    .load_pc    (load_pc),
    .load_fault (load_fault),
    .out_ready  (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .inst_valid (inst_valid)
  );

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// Directed bench for the fetch unit: boot fetch, stalls, bus error,
// misaligned pc, ignored go pulses and reset in the middle of a fetch.
module tb_ysyx_23060278_ifu;
  import ysyx_23060278_ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_go;
  logic        busy;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_valid;
  logic        inst_ready;

  int total = 0;
  int bad   = 0;
  int ar_cnt = 0;

  ysyx_23060278_ifu #(.ADDR_W(32), .DATA_W(32), .BOOT_FETCH(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .fetch_go   (fetch_go),
    .busy       (busy),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (arvalid && arready) ar_cnt <= ar_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = RESET_PC; fetch_go = 1'b0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0; inst_ready = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
    total++; if (arvalid !== 1'b0 || rready !== 1'b0) begin bad++; $display("FAIL reset_chan got=%b%b want=00", arvalid, rready); end
    total++; if (inst_valid !== 1'b0 || inst_fault !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b want=00", inst_valid, inst_fault); end
    total++; if (inst !== 32'h0 || inst_pc !== 32'h0 || araddr !== 32'h0) begin bad++; $display("FAIL reset_data got=%h %h %h want=0", inst, inst_pc, araddr); end
  endtask

  task automatic test_boot_fetch();
    arready = 1'b1;
    rst = 1'b0;
    tick();
    total++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin bad++; $display("FAIL boot_ar got=%b %h want=1 80000000", arvalid, araddr); end
    tick();
    arready = 1'b0;
    total++; if (rready !== 1'b1 || arvalid !== 1'b0) begin bad++; $display("FAIL boot_r got=%b%b want=10", rready, arvalid); end
    rvalid = 1'b1; rdata = 32'h0000_0413;
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL boot_registered got=%b want=0", inst_valid); end
    tick();
    rvalid = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000 || inst_fault !== 1'b0)
      begin bad++; $display("FAIL boot_out got=%b %h %h %b want=1 00000413 80000000 0", inst_valid, inst, inst_pc, inst_fault); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL boot_rready_out got=%b want=0", rready); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if (inst_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL boot_idle got=%b%b want=00", inst_valid, busy); end
  endtask

  task automatic test_stalls();
    int base;
    base = ar_cnt;
    pc = 32'h8000_0008; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0; pc = 32'h8000_1000;
    for (int i = 0; i < 3; i++) begin
      total++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0008) begin bad++; $display("FAIL stall_ar%0d got=%b %h want=1 80000008", i, arvalid, araddr); end
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (rready !== 1'b1 || inst_valid !== 1'b0 || arvalid !== 1'b0) begin bad++; $display("FAIL stall_r%0d got=%b%b%b want=100", i, rready, inst_valid, arvalid); end
      tick();
    end
    rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0; rdata = 32'hffff_ffff;
    for (int i = 0; i < 5; i++) begin
      total++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h8000_0008 || inst_fault !== 1'b0)
        begin bad++; $display("FAIL stall_out%0d got=%b %h %h %b want=1 12345678 80000008 0", i, inst_valid, inst, inst_pc, inst_fault); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if (inst_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b%b want=00", inst_valid, busy); end
    total++; if (ar_cnt - base !== 1) begin bad++; $display("FAIL stall_ar_count got=%0d want=1", ar_cnt - base); end
  endtask

  task automatic test_bus_error();
    pc = 32'h8000_0004; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hdead_beef;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    total++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0004 || inst !== 32'hdead_beef)
      begin bad++; $display("FAIL buserr_out got=%b %b %h %h want=1 1 80000004 deadbeef", inst_valid, inst_fault, inst_pc, inst); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if (busy !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL buserr_idle got=%b%b want=00", busy, inst_valid); end
  endtask

  task automatic test_misaligned();
    int base;
    int waited;
    logic saw_ar;
    base = ar_cnt; waited = 0; saw_ar = 1'b0;
    arready = 1'b1;
    pc = 32'h8000_0002; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    while (!inst_valid && waited < 4) begin
      if (arvalid) saw_ar = 1'b1;
      tick();
      waited++;
    end
    if (arvalid) saw_ar = 1'b1;
    total++; if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0002)
      begin bad++; $display("FAIL misalign_out got=%b %h %b %h want=1 0 1 80000002", inst_valid, inst, inst_fault, inst_pc); end
    total++; if (saw_ar !== 1'b0 || ar_cnt - base !== 0) begin bad++; $display("FAIL misalign_bus got=%b %0d want=0 0", saw_ar, ar_cnt - base); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; arready = 1'b0;
    total++; if (busy !== 1'b0 || arvalid !== 1'b0) begin bad++; $display("FAIL misalign_idle got=%b%b want=00", busy, arvalid); end
  endtask

  task automatic test_ignored_go();
    int base;
    base = ar_cnt;
    pc = 32'h8000_000c; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b1; pc = 32'h8000_0010;
    tick();
    fetch_go = 1'b0;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h8000_000c) begin bad++; $display("FAIL ign_ar got=%b %h want=1 8000000c", arvalid, araddr); end
    arready = 1'b1;
    tick();
    arready = 1'b0; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    total++; if (rready !== 1'b1 || arvalid !== 1'b0) begin bad++; $display("FAIL ign_r got=%b%b want=10", rready, arvalid); end
    rvalid = 1'b1; rdata = 32'h0010_0093;
    tick();
    rvalid = 1'b0; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    total++; if (busy !== 1'b1 || inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_000c)
      begin bad++; $display("FAIL ign_out got=%b %b %h %h want=1 1 00100093 8000000c", busy, inst_valid, inst, inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b want=0", busy); end
    tick();
    tick();
    total++; if (arvalid !== 1'b0 || ar_cnt - base !== 1) begin bad++; $display("FAIL ign_count got=%b %0d want=0 1", arvalid, ar_cnt - base); end
  endtask

  task automatic test_reset_mid_fetch();
    pc = 32'h8000_0014; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL rstmid_inr got=%b want=1", rready); end
    rst = 1'b1;
    #1;
    total++; if (rready !== 1'b0 || arvalid !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL rstmid_async got=%b%b%b%b want=0001", rready, arvalid, inst_valid, busy); end
    pc = 32'h8000_0020; arready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    total++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0020) begin bad++; $display("FAIL rstmid_refetch got=%b %h want=1 80000020", arvalid, araddr); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
    tick();
    rvalid = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0020 || inst !== 32'h0000_0013)
      begin bad++; $display("FAIL rstmid_out got=%b %h %h want=1 80000020 00000013", inst_valid, inst_pc, inst); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stalls();
    test_bus_error();
    test_misaligned();
    test_ignored_go();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
